mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Sequences and shares the single memory bus among three L1 miss/eviction requesters: dirty-line writeback, data-read miss, instruction-read miss.
- Turns each client request into a whole-line bus transaction (1 address phase plus 8 beats of 64 bits, i.e. a 64 B line).
- Returns the filled line, or write completion, to the owning client.
- Sits between the cache datapath and the bus_req/bus_resp interface.

Parameters:
- DATA_W, 64, bus beat width in bits.
- TAG_W, 13, bus tag width.
- ADDR_W, 64, address width.
- BEATS, 8, beats per cache line (line = BEATS*DATA_W bits).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset; one clock domain
- wb_valid  in  1  writeback request
- wb_addr  in  ADDR_W  writeback line address
- wb_line  in  BEATS*DATA_W  dirty line, beat 0 in LSBs
- wb_ready  out  1  writeback accepted (1-cycle pulse)
- wb_done  out  1  writeback completed (1-cycle pulse)
- dr_valid / ir_valid  in  1  data-read / instruction-read miss request
- dr_addr / ir_addr  in  ADDR_W  miss address
- dr_ready / ir_ready  out  1  request accepted (1-cycle pulse)
- fill_valid  out  1  fill line ready (1-cycle pulse)
- fill_client  out  2  owner of fill: 1 = data, 2 = instruction
- fill_addr  out  ADDR_W  line-aligned fill address
- fill_line  out  BEATS*DATA_W  filled line, beat 0 in LSBs
- bus_reqcyc  out  1  request/beat valid
- bus_reqack  in  1  memory accepted the address phase
- bus_req  out  DATA_W  address or write-data beat
- bus_reqtag  out  TAG_W  MEM_READ_TAG or MEM_WRITE_TAG
- bus_respcyc  in  1  response beat valid
- bus_respack  out  1  response beat acknowledged
- bus_resp  in  DATA_W  response data
- bus_resptag  in  TAG_W  response tag

Behaviour:
- Reset (reset == 0 at a posedge):
  - State goes to IDLE and the beat counter clears.
  - Every output goes to 0.
  - Any partial line or in-flight transaction is abandoned. No ready/done/fill pulse is issued for it.
- Arbitration happens only in IDLE. Order is writeback, then data read, then instruction read.
  - The winner gets its *_ready pulse in the same cycle.
  - Its address, with the low 6 bits forced to zero, and its line if any, are latched.
  - Losers keep their valid high and wait. Clients must hold valid until ready.
- State machine:
  - IDLE -> REQ when any valid is high.
  - REQ: drive bus_reqcyc=1, bus_req=latched address, bus_reqtag=MEM_WRITE_TAG for writeback or MEM_READ_TAG for reads. Hold until bus_reqack=1.
    - On ack, a write goes to WDATA and a read goes to RDATA.
    - Address phase lasts at least 1 cycle.
  - WDATA: beat k (k = 0..BEATS-1) goes on bus_req with bus_reqcyc=1, one beat per cycle, with no backpressure. After beat BEATS-1, bus_reqcyc=0 and the block goes to WRESP.
  - WRESP: wait for bus_respcyc with bus_resptag==MEM_WRITE_TAG.
    - bus_respack=1 in that same cycle (combinational), and the block goes to DONE.
    - Write latency is 1 + BEATS + memory cycles.
  - RDATA: each cycle with bus_respcyc=1 and bus_resptag==MEM_READ_TAG:
    - store bus_resp into beat[cnt];
    - drive bus_respack=1 in that same cycle;
    - increment cnt.
    - Beats with any other tag get respack=0 and are not stored.
    - When the beat with cnt == BEATS-1 is stored, go to DONE.
  - DONE (1 cycle):
    - For a write, pulse wb_done.
    - For a read, pulse fill_valid, with fill_client/fill_addr/fill_line stable in that cycle.
    - Then return to IDLE.
- No new grant is issued while a transaction is in progress; there is one outstanding transaction.
- Back-to-back: a request valid in the DONE cycle is granted in the following IDLE cycle, so the minimum gap between transactions is 1 idle cycle.
- The beat counter is log2(BEATS) bits and wraps to 0 when DONE is entered.
- bus_reqack arriving outside REQ is ignored. bus_respcyc arriving in IDLE/REQ/WDATA gets respack=0.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Data read and instruction read alternate priority. The one not granted last gets priority next time.
  - The last-grant flag resets to "instruction granted", so data wins the first tie.
  - Writeback stays strictly highest.
- Undefined: fixed priority writeback > data > instruction.

Decomposition:
- Shared package holds:
  - MEM_READ_TAG and MEM_WRITE_TAG constants;
  - the arb_state_t enum {IDLE, REQ, WDATA, WRESP, RDATA, DONE};
  - the client_id_t enum {NONE=0, DATA=1, INSTR=2, WB=3};
  - the LINE_OFFSET_BITS = 6 constant.
- One natural sub-module: mem_line_assembler, the beat counter plus line shift/store register, shared by WDATA beat selection and RDATA capture.

Test Plan:
- Single instruction miss:
  - Stimulus: ir_addr=0x1047; ack after 2 cycles; 8 beats 0x11..0x88.
  - Required: bus_req=0x1040 with MEM_READ_TAG; 8 respacks; fill_valid with fill_client=2, fill_addr=0x1040, fill_line beat0=0x11 … beat7=0x88.
- Writeback:
  - Stimulus: wb_addr=0x2000, line beats 0xA0..0xA7.
  - Required: address phase 0x2000 with MEM_WRITE_TAG, then 8 consecutive beats 0xA0..0xA7; wb_done pulses 1 cycle after the write response is acked.
- Simultaneous requests:
  - Stimulus: wb/dr/ir all valid in the same cycle.
  - Required: grants in order wb, dr, ir, one transaction at a time, each ready a single pulse.
- Tie between data and instruction, repeated twice:
  - With ARB_ROUND_ROBIN_EN: grants dr, ir.
  - Without it: dr, dr while dr stays valid.
- Reset mid-read:
  - Stimulus: reset low after 3 beats.
  - Required: all outputs 0 next cycle, no fill_valid; a new ir request then completes normally.
- Stray traffic:
  - Stimulus: respcyc with a wrong tag during RDATA, and reqack while in IDLE.
  - Required: no respack, beat not stored, state unchanged.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter_pkg : bus tags, FSM/client encodings and line geometry
// Rev 1.0
// ============================================================================
package mem_bus_arbiter_pkg;

  localparam logic [12:0] MEM_READ_TAG     = 13'h00A5;
  localparam logic [12:0] MEM_WRITE_TAG    = 13'h015A;
  localparam int          LINE_OFFSET_BITS = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    WB    = 2'd3
  } client_id_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_line.sv
`default_nettype none
// ============================================================================
// mem_line_assembler : beat counter plus line register; serves write beats
// out and captures read beats in, beat 0 in the LSBs.
// Rev 1.0
// ============================================================================
module mem_line_assembler #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int CNT_W  = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [BEATS*DATA_W-1:0] line_i,
  input  logic                    store_i,
  input  logic [DATA_W-1:0]       beat_i,
  input  logic                    adv_i,
  output logic [CNT_W-1:0]        cnt_o,
  output logic [DATA_W-1:0]       beat_o,
  output logic [BEATS*DATA_W-1:0] line_o
);

  logic [BEATS-1:0][DATA_W-1:0] line_q;
  logic [CNT_W-1:0]             cnt_q;

  // The counter wraps naturally after the last beat, so it is 0 on entry to DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      line_q <= line_i;
      cnt_q  <= '0;
    end else begin
      if (store_i) line_q[cnt_q] <= beat_i;
      if (adv_i)   cnt_q         <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign beat_o = line_q[cnt_q];
  assign line_o = line_q;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : shares one memory bus among writeback, data-miss and
// instruction-miss clients, one whole-line transaction at a time.
// Optional build macro: ARB_ROUND_ROBIN_EN (data/instr alternate priority).
// Rev 1.0
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13,
  parameter int ADDR_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_valid,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [BEATS*DATA_W-1:0] wb_line,
  output logic                    wb_ready,
  output logic                    wb_done,
  input  logic                    dr_valid,
  input  logic [ADDR_W-1:0]       dr_addr,
  output logic                    dr_ready,
  input  logic                    ir_valid,
  input  logic [ADDR_W-1:0]       ir_addr,
  output logic                    ir_ready,
  output logic                    fill_valid,
  output logic [1:0]              fill_client,
  output logic [ADDR_W-1:0]       fill_addr,
  output logic [BEATS*DATA_W-1:0] fill_line,
  output logic                    bus_reqcyc,
  input  logic                    bus_reqack,
  output logic [DATA_W-1:0]       bus_req,
  output logic [TAG_W-1:0]        bus_reqtag,
  input  logic                    bus_respcyc,
  output logic                    bus_respack,
  input  logic [DATA_W-1:0]       bus_resp,
  input  logic [TAG_W-1:0]        bus_resptag
);

  localparam int               CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

  arb_state_t              state_q, state_d;
  client_id_t              client_q, client_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    grant_wb, grant_dr, grant_ir, grant_any;
  logic                    rd_beat, wr_resp;
  logic [CNT_W-1:0]        beat_cnt;
  logic [DATA_W-1:0]       wr_beat;
  logic [BEATS*DATA_W-1:0] line;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_instr_q;

  // Starts as "instruction granted" so data wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset)        last_instr_q <= 1'b1;
    else if (grant_dr) last_instr_q <= 1'b0;
    else if (grant_ir) last_instr_q <= 1'b1;
  end
`endif

  always_comb begin
    grant_wb = 1'b0;
    grant_dr = 1'b0;
    grant_ir = 1'b0;
    if (state_q == IDLE && reset) begin
      if (wb_valid) begin
        grant_wb = 1'b1;
      end else if (dr_valid && ir_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_dr = last_instr_q;
        grant_ir = !last_instr_q;
`else
        grant_dr = 1'b1;
`endif
      end else begin
        grant_dr = dr_valid;
        grant_ir = ir_valid;
      end
    end
  end

  assign grant_any = grant_wb | grant_dr | grant_ir;
  assign rd_beat   = (state_q == RDATA) && bus_respcyc && (bus_resptag == TAG_W'(MEM_READ_TAG));
  assign wr_resp   = (state_q == WRESP) && bus_respcyc && (bus_resptag == TAG_W'(MEM_WRITE_TAG));

  always_comb begin
    state_d  = state_q;
    client_d = client_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: if (grant_any) begin
        state_d  = REQ;
        client_d = grant_wb ? WB : (grant_dr ? DATA : INSTR);
        addr_d   = (grant_wb ? wb_addr : (grant_dr ? dr_addr : ir_addr)) & ~OFF_MASK;
      end
      REQ:     if (bus_reqack) state_d = (client_q == WB) ? WDATA : RDATA;
      WDATA:   if (beat_cnt == LAST_BEAT) state_d = WRESP;
      WRESP:   if (wr_resp) state_d = DONE;
      RDATA:   if (rd_beat && beat_cnt == LAST_BEAT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      client_q <= NONE;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      client_q <= client_d;
      addr_q   <= addr_d;
    end
  end

  mem_line_assembler #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS),
    .CNT_W  (CNT_W)
  ) u_line_asm (
    .clk     (clk),
    .reset   (reset),
    .load_i  (grant_any),
    .line_i  (grant_wb ? wb_line : '0),
    .store_i (rd_beat),
    .beat_i  (bus_resp),
    .adv_i   ((state_q == WDATA) | rd_beat),
    .cnt_o   (beat_cnt),
    .beat_o  (wr_beat),
    .line_o  (line)
  );

  assign wb_ready    = grant_wb;
  assign dr_ready    = grant_dr;
  assign ir_ready    = grant_ir;
  assign wb_done     = (state_q == DONE) && (client_q == WB);
  assign fill_valid  = (state_q == DONE) && (client_q != WB);
  assign fill_client = fill_valid ? client_q : 2'd0;
  assign fill_addr   = fill_valid ? addr_q : '0;
  assign fill_line   = fill_valid ? line : '0;
  assign bus_reqcyc  = (state_q == REQ) || (state_q == WDATA);
  assign bus_req     = (state_q == REQ)   ? DATA_W'(addr_q) :
                       (state_q == WDATA) ? wr_beat : '0;
  assign bus_reqtag  = (state_q != REQ)   ? '0 :
                       (client_q == WB)   ? TAG_W'(MEM_WRITE_TAG) : TAG_W'(MEM_READ_TAG);
  assign bus_respack = rd_beat | wr_resp;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : directed bench with a bus-memory responder and a
// transaction-level model checked every cycle.
// Rev 1.0
// ============================================================================
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_valid, dr_valid, ir_valid;
  logic [63:0]  wb_addr, dr_addr, ir_addr;
  logic [511:0] wb_line;
  logic         wb_ready, wb_done, dr_ready, ir_ready;
  logic         fill_valid;
  logic [1:0]   fill_client;
  logic [63:0]  fill_addr;
  logic [511:0] fill_line;
  logic         bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0]  bus_req, bus_resp;
  logic [12:0]  bus_reqtag, bus_resptag;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_line(wb_line),
    .wb_ready(wb_ready), .wb_done(wb_done),
    .dr_valid(dr_valid), .dr_addr(dr_addr), .dr_ready(dr_ready),
    .ir_valid(ir_valid), .ir_addr(ir_addr), .ir_ready(ir_ready),
    .fill_valid(fill_valid), .fill_client(fill_client),
    .fill_addr(fill_addr), .fill_line(fill_line),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Arbitration rule: writeback first, then data/instruction.
  function automatic int arb(input logic w, input logic d, input logic i, input bit last_i);
    if (w) return 3;
    if (d && i) begin
`ifdef ARB_ROUND_ROBIN_EN
      return last_i ? 1 : 2;
`else
      return 1;
`endif
    end
    if (d) return 1;
    if (i) return 2;
    return 0;
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a, input int k);
    if (a == 64'h1040) return 64'((k + 1) * 17);
    return (a << 16) | 64'(k + 1);
  endfunction

  // ---------------- memory responder ----------------
  int  ack_delay = 0, resp_delay = 0, stray_k = -1;
  bit  stray_ack = 0;
  int  mph, mcnt, mem_k;
  bit  mem_wr, injected;
  logic [63:0] mem_addr;

  initial begin
    bus_reqack = 0; bus_respcyc = 0; bus_resptag = '0; bus_resp = '0; mph = 0;
    forever begin
      @(posedge clk); #2;
      bus_reqack = 0; bus_respcyc = 0; bus_resptag = '0; bus_resp = '0;
      if (!reset) mph = 0;
      else begin
        if (mph == 0) begin
          if (bus_reqcyc) begin
            mem_addr = bus_req; mem_wr = (bus_reqtag == MEM_WRITE_TAG);
            mcnt = 0; mem_k = 0; injected = 0; mph = 1;
          end else if (stray_ack) bus_reqack = 1;
        end
        if (mph == 1) begin
          if (mcnt == ack_delay) begin bus_reqack = 1; mph = mem_wr ? 2 : 4; mcnt = 0; end
          else mcnt++;
        end else if (mph == 2) begin
          if (!bus_reqcyc) begin
            if (mcnt == resp_delay) begin bus_respcyc = 1; bus_resptag = MEM_WRITE_TAG; mph = 0; end
            else mcnt++;
          end
        end else if (mph == 4) begin
          bus_respcyc = 1;
          if (mem_k == stray_k && !injected) begin
            bus_resptag = 13'h1FFF; bus_resp = 64'hDEAD_BEEF; injected = 1;
          end else begin
            bus_resptag = MEM_READ_TAG; bus_resp = mem_word(mem_addr, mem_k); mem_k++;
            if (mem_k == 8) mph = 0;
          end
        end
      end
    end
  end

  // ---------------- clients drop valid after their ready ----------------
  bit s_wb, s_dr, s_ir;
  initial forever begin
    @(negedge clk); s_wb = wb_ready; s_dr = dr_ready; s_ir = ir_ready;
    @(posedge clk); #1;
    if (s_wb) wb_valid = 0;
    if (s_dr) dr_valid = 0;
    if (s_ir) ir_valid = 0;
  end

  // ---------------- transaction model + per-cycle compare ----------------
  int ph = 0, mk = 0, m_client = 0, win;
  bit last_i = 1, rst_prev = 0, acc_w, acc_r;
  logic [63:0]  m_addr;
  logic [511:0] m_line;
  int n_done = 0, n_rbeats = 0, n_respack = 0;
  int grants[$];
  logic [63:0] wr_beats[$];
  logic [63:0] last_aph_addr;
  logic [12:0] last_aph_tag;
  logic [63:0] last_fill_addr;
  logic [1:0]  last_fill_client;
  logic [511:0] last_fill_line;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (rst_prev) begin
        chk("reset_outs", {wb_ready, wb_done, dr_ready, ir_ready, fill_valid, fill_client,
                           fill_addr, bus_reqcyc, bus_req, bus_reqtag, bus_respack}, '0);
        chk("reset_fill_line", fill_line, '0);
      end
      ph = 0; last_i = 1; rst_prev = 1;
    end else begin
      rst_prev = 0;
      win = (ph == 0) ? arb(wb_valid, dr_valid, ir_valid, last_i) : 0;
      chk("wb_ready", wb_ready, win == 3);
      chk("dr_ready", dr_ready, win == 1);
      chk("ir_ready", ir_ready, win == 2);
      chk("reqcyc", bus_reqcyc, ph == 1 || ph == 2);
      if (ph == 1) begin
        chk("addr_phase", bus_req, m_addr);
        chk("addr_tag", bus_reqtag, (m_client == 3) ? MEM_WRITE_TAG : MEM_READ_TAG);
        last_aph_addr = bus_req; last_aph_tag = bus_reqtag;
      end
      if (ph == 2) begin
        chk("wdata_beat", bus_req, m_line[mk*64 +: 64]);
        wr_beats.push_back(bus_req);
      end
      acc_w = (ph == 3) && bus_respcyc && (bus_resptag == MEM_WRITE_TAG);
      acc_r = (ph == 4) && bus_respcyc && (bus_resptag == MEM_READ_TAG);
      chk("respack", bus_respack, acc_w || acc_r);
      if (bus_respack) n_respack++;
      chk("wb_done", wb_done, ph == 5 && m_client == 3);
      chk("fill_valid", fill_valid, ph == 5 && m_client != 3);
      if (ph == 5 && m_client != 3) begin
        chk("fill_client", fill_client, m_client);
        chk("fill_addr", fill_addr, m_addr);
        chk("fill_line", fill_line, m_line);
        last_fill_addr = fill_addr; last_fill_client = fill_client; last_fill_line = fill_line;
      end
      case (ph)
        0: if (win != 0) begin
          ph = 1; mk = 0; m_client = win; grants.push_back(win);
          m_addr = ((win == 3) ? wb_addr : (win == 1) ? dr_addr : ir_addr) & ~64'h3F;
          m_line = (win == 3) ? wb_line : '0;
          if (win == 1) last_i = 0;
          if (win == 2) last_i = 1;
        end
        1: if (bus_reqack) begin ph = (m_client == 3) ? 2 : 4; mk = 0; end
        2: begin mk++; if (mk == 8) ph = 3; end
        3: if (acc_w) ph = 5;
        4: if (acc_r) begin
          m_line[mk*64 +: 64] = bus_resp; mk++; n_rbeats++;
          if (mk == 8) ph = 5;
        end
        default: begin ph = 0; n_done++; end
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (n_done < target && c < budget) begin @(posedge clk); #1; c++; end
    chk("txn_complete", n_done >= target, 1'b1);
  endtask

  function automatic int g(input int k);
    return (grants.size() > k) ? grants[k] : -1;
  endfunction

  int nd, base_ack, base_rb, c;
  logic [511:0] exp_line;

  initial begin
    reset = 0; wb_valid = 0; dr_valid = 0; ir_valid = 0;
    wb_addr = '0; dr_addr = '0; ir_addr = '0; wb_line = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // single instruction miss
    grants.delete(); base_ack = n_respack; ack_delay = 2;
    ir_addr = 64'h1047; ir_valid = 1;
    wait_done(n_done + 1, 100);
    for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = 64'((k + 1) * 17);
    chk("t1_grant", g(0), 2);
    chk("t1_aph_addr", last_aph_addr, 64'h1040);
    chk("t1_aph_tag", last_aph_tag, MEM_READ_TAG);
    chk("t1_respacks", n_respack - base_ack, 8);
    chk("t1_fill_client", last_fill_client, 2'd2);
    chk("t1_fill_addr", last_fill_addr, 64'h1040);
    chk("t1_fill_line", last_fill_line, exp_line);

    // writeback
    grants.delete(); wr_beats.delete(); ack_delay = 0; resp_delay = 3;
    for (int k = 0; k < 8; k++) wb_line[k*64 +: 64] = 64'hA0 + 64'(k);
    wb_addr = 64'h2000; wb_valid = 1;
    wait_done(n_done + 1, 100);
    chk("t2_aph_addr", last_aph_addr, 64'h2000);
    chk("t2_aph_tag", last_aph_tag, MEM_WRITE_TAG);
    chk("t2_nbeats", wr_beats.size(), 8);
    for (int k = 0; k < 8 && k < wr_beats.size(); k++) chk("t2_beat", wr_beats[k], 64'hA0 + 64'(k));

    // simultaneous requests
    grants.delete(); nd = n_done; ack_delay = 1; resp_delay = 0;
    for (int k = 0; k < 8; k++) wb_line[k*64 +: 64] = 64'hB0 + 64'(k);
    wb_addr = 64'h5000; dr_addr = 64'h6008; ir_addr = 64'h7010;
    wb_valid = 1; dr_valid = 1; ir_valid = 1;
    wait_done(nd + 3, 200);
    chk("t3_grant0", g(0), 3);
    chk("t3_grant1", g(1), 1);
    chk("t3_grant2", g(2), 2);

    // data/instruction tie twice
    grants.delete(); nd = n_done;
    dr_addr = 64'h9000; ir_addr = 64'hA000; dr_valid = 1; ir_valid = 1;
    wait_done(nd + 1, 100);
    dr_valid = 1;
    wait_done(nd + 3, 200);
    chk("t4_tie0", g(0), 1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t4_tie1", g(1), 2);
`else
    chk("t4_tie1", g(1), 1);
`endif

    // reset mid-read
    nd = n_done; base_rb = n_rbeats; ack_delay = 0;
    ir_addr = 64'h3000; ir_valid = 1;
    c = 0;
    while (n_rbeats < base_rb + 3 && c < 100) begin @(posedge clk); #1; c++; end
    chk("t5_three_beats", n_rbeats >= base_rb + 3, 1'b1);
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    chk("t5_no_fill", n_done, nd);
    ir_addr = 64'h3044; ir_valid = 1;
    wait_done(nd + 1, 100);
    chk("t5_fill_addr", last_fill_addr, 64'h3040);
    chk("t5_fill_beat0", last_fill_line[63:0], 64'h3040_0001);

    // stray traffic: wrong-tag beat in RDATA, reqack in IDLE
    base_ack = n_respack; nd = n_done; stray_k = 2;
    dr_addr = 64'h8010; dr_valid = 1;
    wait_done(nd + 1, 100);
    stray_k = -1;
    chk("t6_respacks", n_respack - base_ack, 8);
    chk("t6_beat2", last_fill_line[191:128], 64'h8000_0003);
    nd = n_done; c = grants.size();
    stray_ack = 1;
    repeat (5) @(posedge clk);
    #1 stray_ack = 0;
    repeat (2) @(posedge clk);
    chk("t6_idle_grants", grants.size(), c);
    chk("t6_idle_done", n_done, nd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
